mc_bus_arb: RTL and testbench
=============================

# mc_bus_arb

Parametrised external-bus request/grant arbiter for the memory-controller memory side. It generalises the single `mc_br_i`/`mc_bg_o` pair to `NUM_CH` external bus masters. It provides round-robin arbitration, a programmable bus-turnaround gap and an optional grant-hold timeout. It sits between the external masters and the memory controller's memory interface, and tells the controller when the shared pins are owned by an external master.

## Interface
Parameters:
- `NUM_CH`, 4, number of external requesters (2..16).
- `TURN_CYC`, 1, idle turnaround cycles after every grant release (1..15).
- `HOLD_MAX`, 64, maximum grant duration in cycles when timeout is compiled in (2..65535).

Ports (all inputs sampled and outputs registered on `mc_clk` rising edge):
- `mc_clk`, in, 1, controller clock.
- `mc_rst`, in, 1, reset; asynchronous, active-high.
- `mc_br_i`, in, NUM_CH, per-channel bus request, level.
- `mc_bg_o`, out, NUM_CH, per-channel bus grant, one-hot or zero.
- `mc_owner_o`, out, $clog2(NUM_CH), index of the current grantee; holds the last grantee when there is no grant.
- `mc_bus_idle_o`, out, 1, high when no grant is active and no turnaround is in progress; the controller may drive the memory pins.
- `mc_timeout_o`, out, 1, one-cycle pulse on a forced grant revocation.

## Operation
- FSM states: IDLE, GRANT, TURN.
- Reset values (async, while `mc_rst`=1): state IDLE, `mc_bg_o`=0, `mc_owner_o`=0, `mc_bus_idle_o`=1, `mc_timeout_o`=0.
  - RR pointer = 0, so channel 0 has highest priority first.
  - Hold counter = 0; revoke mask = 0.
- IDLE: if any eligible request exists, pick the first eligible channel at or after the pointer, wrapping NUM_CH-1 to 0.
  - Eligible means `mc_br_i[i]`=1 and `mask[i]`=0.
  - Go to GRANT; set `mc_bg_o[winner]`, `mc_owner_o`=winner, `mc_bus_idle_o`=0.
  - Pointer becomes (winner+1) mod NUM_CH.
- GRANT: the grant holds while `mc_br_i[owner]`=1. Requests on other channels do not preempt.
  - When the owner's `mc_br_i` is sampled low: clear `mc_bg_o`, go to TURN, load the turnaround counter with TURN_CYC.
- TURN: `mc_bg_o`=0 and `mc_bus_idle_o`=0 for exactly TURN_CYC cycles.
  - At the edge ending the last TURN cycle, arbitrate as in IDLE and go directly to GRANT if a winner exists; otherwise go to IDLE with `mc_bus_idle_o`=1.
- Revoke mask: bit i is set on a forced revocation of channel i. It clears on the first edge where `mc_br_i[i]`=0.
- A request dropped during TURN, or before it is granted, is simply not considered; there is no latching of requests.
- Reset asserted mid-grant drops `mc_bg_o` immediately (asynchronously); no turnaround is performed.

## Timing
- Grant latency from IDLE: `mc_br_i` high sampled at edge k gives `mc_bg_o` high after edge k (visible in cycle k+1).
- Release: owner `mc_br_i` low sampled at edge k gives `mc_bg_o` low after edge k.
  - The next grant can appear no earlier than after edge k+TURN_CYC.
  - `mc_bus_idle_o` rises after edge k+TURN_CYC if no requests are pending.
- Simultaneous requests resolve in the same edge by pointer order. An owner release and a new request in the same cycle still incur the full TURN.
- Single requester with continuous requests: each grant ends only when that requester drops `mc_br_i`.

## Configuration
- `MC_ARB_TIMEOUT_EN` defined:
  - The hold counter counts cycles in GRANT from 1.
  - If it reaches HOLD_MAX with the owner's `mc_br_i` still 1, that edge:
    - clears `mc_bg_o`,
    - pulses `mc_timeout_o` for one cycle,
    - sets `mask[owner]`,
    - enters TURN.
  - The counter clears on each new grant.
- `MC_ARB_TIMEOUT_EN` not defined:
  - No hold counter and no mask logic; the mask is effectively 0.
  - `mc_timeout_o` is tied 0.
  - A grant lasts indefinitely.

## Test plan
- Reset: assert `mc_rst` mid-cycle with ch2 granted. `mc_bg_o`=0 immediately, `mc_bus_idle_o`=1, `mc_owner_o`=0. After release, a request on ch1 is granted 1 cycle later.
- NUM_CH=4, TURN_CYC=1, all four requesters raise `mc_br_i` together and each holds 3 cycles once granted. Grant order is 0,1,2,3. Each grant lasts 3 cycles with exactly 1 idle gap between grants.
- Wrap-around with pointer at 3 after granting ch2: ch0 and ch3 request together. ch3 is granted first, then ch0.
- TURN_CYC=3: ch1 drops at edge k while ch0 is requesting. `mc_bg_o[0]` rises after edge k+3 and `mc_bus_idle_o` stays 0 throughout.
- With `MC_ARB_TIMEOUT_EN`, HOLD_MAX=8, ch0 holds `mc_br_i` high forever and ch1 requests. `mc_bg_o[0]` drops after 8 grant cycles and `mc_timeout_o` pulses once. ch1 is granted after TURN. ch0 is not re-granted until it drops `mc_br_i` for at least one cycle.
- Without the macro, same stimulus: ch0 keeps its grant for 1000 cycles and `mc_timeout_o` stays 0.

Source files
------------

// File: rtl/mc_bus_arb.sv
// Round-robin request/grant arbiter for NUM_CH external bus masters sharing the memory pins.
// Optional grant-hold timeout with revoke masking is compiled in by defining MC_ARB_TIMEOUT_EN.
module mc_bus_arb #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic                      mc_clk,
  input  logic                      mc_rst,
  input  logic [NUM_CH-1:0]         mc_br_i,
  output logic [NUM_CH-1:0]         mc_bg_o,
  output logic [$clog2(NUM_CH)-1:0] mc_owner_o,
  output logic                      mc_bus_idle_o,
  output logic                      mc_timeout_o
);

  localparam int unsigned OwnW = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 16 || TURN_CYC < 1 || TURN_CYC > 15 ||
      HOLD_MAX < 2 || HOLD_MAX > 65535) begin : g_param_check
    $error("mc_bus_arb: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] bg_q, bg_d;
  logic [OwnW-1:0]   owner_q, owner_d;
  logic [OwnW-1:0]   ptr_q, ptr_d;
  logic [3:0]        turn_q, turn_d;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] elig;
  logic [OwnW-1:0]   win;
  logic              found;
  logic              arb;

`ifdef MC_ARB_TIMEOUT_EN
  logic [NUM_CH-1:0] mask_d;
  logic [15:0]       hold_q, hold_d;
  logic              timeout_q, timeout_d;
`else
  assign mask = '0;
`endif

  assign elig = mc_br_i & ~mask;

  // First eligible channel at or after the pointer, wrapping.
  always_comb begin : p_pick
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      idx = (32'(ptr_q) + off) % NUM_CH;
      if (!found && elig[idx[OwnW-1:0]]) begin
        found = 1'b1;
        win   = idx[OwnW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    turn_d  = turn_q;
    arb     = 1'b0;
`ifdef MC_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    mask_d    = mask & mc_br_i;
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: arb = 1'b1;
      StGrant: begin
        if (!mc_br_i[owner_q]) begin
          state_d = StTurn;
          bg_d    = '0;
          turn_d  = 4'(TURN_CYC);
`ifdef MC_ARB_TIMEOUT_EN
        end else if (hold_q == 16'(HOLD_MAX)) begin
          state_d         = StTurn;
          bg_d            = '0;
          turn_d          = 4'(TURN_CYC);
          timeout_d       = 1'b1;
          mask_d[owner_q] = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
`endif
        end
      end
      StTurn: begin
        if (turn_q == 4'd1) begin
          arb = 1'b1;
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (arb) begin
      state_d = StIdle;
      if (found) begin
        state_d   = StGrant;
        bg_d      = '0;
        bg_d[win] = 1'b1;
        owner_d   = win;
        ptr_d     = (win == OwnW'(NUM_CH - 1)) ? '0 : win + 1'b1;
`ifdef MC_ARB_TIMEOUT_EN
        hold_d    = 16'd1;
`endif
      end
    end
  end

  always_ff @(posedge mc_clk or posedge mc_rst) begin
    if (mc_rst) begin
      state_q <= StIdle;
      bg_q    <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      turn_q  <= turn_d;
    end
  end

`ifdef MC_ARB_TIMEOUT_EN
  always_ff @(posedge mc_clk or posedge mc_rst) begin
    if (mc_rst) begin
      hold_q    <= '0;
      mask      <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      mask      <= mask_d;
      timeout_q <= timeout_d;
    end
  end

  assign mc_timeout_o = timeout_q;
`else
  assign mc_timeout_o = 1'b0;
`endif

  assign mc_bg_o       = bg_q;
  assign mc_owner_o    = owner_q;
  assign mc_bus_idle_o = (state_q == StIdle);

endmodule

// File: tb/tb_mc_bus_arb.sv
// Bench for mc_bus_arb: two instances (TURN_CYC=1 and 3) on a shared request bus, checked every
// cycle against a behavioural model, plus directed scenarios and a randomized phase.
module tb_mc_bus_arb;

  localparam int unsigned HOLD = 8;
`ifdef MC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] br  = '0;
  logic [3:0] bg1, bg3;
  logic [1:0] own1, own3;
  logic       idle1, idle3, to1, to3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mc_bus_arb #(.NUM_CH(4), .TURN_CYC(1), .HOLD_MAX(HOLD)) dut1 (
    .mc_clk(clk), .mc_rst(rst), .mc_br_i(br), .mc_bg_o(bg1), .mc_owner_o(own1),
    .mc_bus_idle_o(idle1), .mc_timeout_o(to1)
  );

  mc_bus_arb #(.NUM_CH(4), .TURN_CYC(3), .HOLD_MAX(HOLD)) dut3 (
    .mc_clk(clk), .mc_rst(rst), .mc_br_i(br), .mc_bg_o(bg3), .mc_owner_o(own3),
    .mc_bus_idle_o(idle3), .mc_timeout_o(to3)
  );

  // Reference model, index 0 -> dut1, index 1 -> dut3.
  int         tcyc[2] = '{1, 3};
  bit         m_gnt[2];
  int         m_own[2], m_gap[2], m_ptr[2], m_hold[2];
  logic [3:0] m_mask[2];
  bit         m_to[2];

  logic [3:0] exp_rr[16] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                             4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_gnt[k] = 0; m_own[k] = 0; m_gap[k] = 0; m_ptr[k] = 0;
      m_hold[k] = 0; m_mask[k] = '0; m_to[k] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] nm;
      bit         can_arb;
      bit         got;
      can_arb = 0;
      got     = 0;
      m_to[k] = 0;
      nm      = m_mask[k] & br;
      if (m_gnt[k]) begin
        if (!br[m_own[k]]) begin
          m_gnt[k] = 0; m_gap[k] = tcyc[k];
        end else if (TO_EN && m_hold[k] == HOLD) begin
          m_gnt[k] = 0; m_gap[k] = tcyc[k]; m_to[k] = 1; nm[m_own[k]] = 1'b1;
        end else begin
          m_hold[k]++;
        end
      end else if (m_gap[k] > 0) begin
        m_gap[k]--;
        can_arb = (m_gap[k] == 0);
      end else begin
        can_arb = 1;
      end
      if (can_arb) begin
        for (int off = 0; off < 4; off++) begin
          int c;
          c = (m_ptr[k] + off) % 4;
          if (!got && br[c] && !m_mask[k][c]) begin
            got = 1; m_gnt[k] = 1; m_own[k] = c; m_hold[k] = 1; m_ptr[k] = (c + 1) % 4;
          end
        end
      end
      m_mask[k] = nm;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("bg1",   32'(bg1),   m_gnt[0] ? 32'(1) << m_own[0] : 32'd0);
    chk("own1",  32'(own1),  32'(m_own[0]));
    chk("idle1", 32'(idle1), 32'(!m_gnt[0] && m_gap[0] == 0));
    chk("to1",   32'(to1),   32'(m_to[0]));
    chk("bg3",   32'(bg3),   m_gnt[1] ? 32'(1) << m_own[1] : 32'd0);
    chk("own3",  32'(own3),  32'(m_own[1]));
    chk("idle3", 32'(idle3), 32'(!m_gnt[1] && m_gap[1] == 0));
    chk("to3",   32'(to3),   32'(m_to[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    br  = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_bg", 32'(bg1), 32'd0);
    chk("rst_owner", 32'(own1), 32'd0);
    chk("rst_idle", 32'(idle1), 32'd1);
    chk("rst_timeout", 32'(to1), 32'd0);
    check_all();

    // Asynchronous reset while ch2 holds the grant.
    br = 4'b0100;
    tick();
    chk("grant_ch2", 32'(bg1), 32'h4);
    tick();
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_bg1", 32'(bg1), 32'd0);
    chk("async_rst_bg3", 32'(bg3), 32'd0);
    chk("async_rst_idle", 32'(idle1), 32'd1);
    chk("async_rst_owner", 32'(own1), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    br = 4'b0010;
    tick();
    chk("post_rst_ch1", 32'(bg1), 32'h2);

    // All four request together; each drops after three granted cycles.
    do_reset();
    br = 4'b1111;
    for (int j = 0; j < 18; j++) begin
      tick();
      if (j < 16) chk("rr_order", 32'(bg1), 32'(exp_rr[j]));
      for (int c = 0; c < 4; c++) if (j >= 4 * c + 2) br[c] = 1'b0;
    end
    chk("rr_idle_end", 32'(idle1), 32'd1);

    // Pointer at 3 after granting ch2: ch3 wins over ch0.
    do_reset();
    br = 4'b0100;
    tick();
    chk("wrap_ch2", 32'(bg1), 32'h4);
    br = 4'b0000;
    tick();
    tick();
    chk("wrap_idle", 32'(idle1), 32'd1);
    br = 4'b1001;
    tick();
    chk("wrap_ch3_first", 32'(bg1), 32'h8);
    br = 4'b0001;
    tick();
    chk("wrap_turn", 32'(bg1), 32'd0);
    tick();
    chk("wrap_ch0_next", 32'(bg1), 32'h1);
    br = 4'b0000;
    repeat (4) tick();

    // Three-cycle turnaround on dut3.
    do_reset();
    br = 4'b0010;
    tick();
    chk("t3_ch1", 32'(bg3), 32'h2);
    br = 4'b0011;
    tick();
    br = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("t3_gap_bg", 32'(bg3), 32'd0);
      chk("t3_gap_idle", 32'(idle3), 32'd0);
    end
    tick();
    chk("t3_ch0", 32'(bg3), 32'h1);
    br = 4'b0000;
    repeat (5) tick();

    // ch0 requests forever, ch1 waits.
    do_reset();
    br = 4'b0011;
`ifdef MC_ARB_TIMEOUT_EN
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("to_hold", 32'(bg1), 32'h1);
      chk("to_quiet", 32'(to1), 32'd0);
    end
    tick();
    chk("to_revoke", 32'(bg1), 32'd0);
    chk("to_pulse", 32'(to1), 32'd1);
    tick();
    chk("to_ch1", 32'(bg1), 32'h2);
    chk("to_pulse_end", 32'(to1), 32'd0);
    br = 4'b0001;
    tick();
    tick();
    chk("to_masked", 32'(bg1), 32'd0);
    chk("to_masked_idle", 32'(idle1), 32'd1);
    repeat (3) tick();
    chk("to_still_masked", 32'(bg1), 32'd0);
    br = 4'b0000;
    tick();
    br = 4'b0001;
    tick();
    chk("to_regrant", 32'(bg1), 32'h1);
`else
    for (int j = 0; j < 1000; j++) begin
      tick();
      chk("hold_forever", 32'(bg1), 32'h1);
      chk("no_timeout", 32'(to1), 32'd0);
    end
`endif
    br = 4'b0000;
    repeat (4) tick();

    // Randomized requests against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      tick();
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) br[b] = ~br[b];
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
